// File: rtl/button_debouncer.sv
// Per-lane button debouncer: a lane accepts a new level only after DEBOUNCE_CYCLES
// consecutive samples at that level, then emits a one-cycle press or release strobe.
module button_debouncer #(
    parameter int N_LANES         = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] btn_sync,
    output logic [N_LANES-1:0] btn_level,
    output logic [N_LANES-1:0] btn_press,
    output logic [N_LANES-1:0] btn_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // lane_state is the per-lane FSM state, kept as a named array so it can be probed.
    state_t             lane_state [N_LANES];
    state_t             state_d    [N_LANES];
    logic [CNT_W-1:0]   cnt_q      [N_LANES];
    logic [CNT_W-1:0]   cnt_d      [N_LANES];
    logic [N_LANES-1:0] level_q, level_d;
    logic [N_LANES-1:0] press_q, press_d;
    logic [N_LANES-1:0] release_q, release_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) begin
                lane_state[i] <= RELEASED;
                cnt_q[i]      <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                lane_state[i] <= state_d[i];
                cnt_q[i]      <= cnt_d[i];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            state_d[i] = lane_state[i];
            cnt_d[i]   = '0;
            unique case (lane_state[i])
                RELEASED: begin
                    if (btn_sync[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_sync[i]) begin
                        state_d[i] = RELEASED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]  = PRESSED;
                        level_d[i]  = 1'b1;
                        press_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_sync[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_sync[i]) begin
                        state_d[i] = PRESSED;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = RELEASED;
                        level_d[i]   = 1'b0;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
